// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: UART byte handshake and instruction-memory write bus of the program loader
interface uart_prog_loader_if #(parameter int ADDR_W = 4);
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              rx_clr;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (input rx_data, rx_rdy, tx_busy, output rx_clr, tx_data, tx_wr, imem_we, imem_addr, imem_wdata);
    modport slave (output rx_data, rx_rdy, tx_busy, input rx_clr, tx_data, tx_wr, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: ASCII-hex program loader, echo and CPU run control; LOADER_AUTOSTART_EN starts the CPU once memory is full
module uart_prog_loader #(parameter int ADDR_W = 4) (
    input  logic                clk,
    input  logic                rst_n,
    uart_prog_loader_if.master  bus,
    input  logic                cpu_halted,
    output logic                cpu_start,
    output logic [ADDR_W:0]     word_cnt,
    output logic                err
);
    typedef enum logic [2:0] {IDLE, ECHO, WRITE, RUN, HALT_TX} state_t;
    state_t      state;
    logic [7:0]  byte_q;
    logic [31:0] word;
    logic [3:0]  nib;
    logic        is_hex;
    logic [3:0]  hex_val;
    logic        fresh;

    // Decode the waiting byte; rx_rdy is stale while our own rx_clr is still high
    always_comb begin
        is_hex  = (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) || (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46);
        hex_val = bus.rx_data[6] ? bus.rx_data[3:0] + 4'd9 : bus.rx_data[3:0];
        fresh   = bus.rx_rdy && !bus.rx_clr;
    end

    // Loader state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_q         <= '0;
            word           <= '0;
            nib            <= '0;
            cpu_start      <= 1'b0;
            word_cnt       <= '0;
            err            <= 1'b0;
            bus.rx_clr     <= 1'b0;
            bus.tx_data    <= '0;
            bus.tx_wr      <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.rx_clr  <= 1'b0;
            bus.tx_wr   <= 1'b0;
            bus.imem_we <= 1'b0;
            case (state)
                IDLE: if (fresh) begin
                    byte_q      <= bus.rx_data;
                    bus.rx_clr  <= 1'b1;
                    bus.tx_data <= bus.rx_data;
                    state       <= ECHO;
                    if (is_hex) begin
                        if (word_cnt[ADDR_W]) begin
                            err         <= 1'b1;
                            bus.tx_data <= 8'h3F;
                        end else begin
                            word <= {word[27:0], hex_val};
                            nib  <= nib + 4'd1;
                        end
                    end else if (bus.rx_data == 8'h52) begin
                        word_cnt <= '0;
                        nib      <= '0;
                        err      <= 1'b0;
                    end else if (!(bus.rx_data inside {8'h47, 8'h0D, 8'h0A})) begin
                        err         <= 1'b1;
                        nib         <= '0;
                        bus.tx_data <= 8'h3F;
                    end
                end
                ECHO: if (!bus.tx_busy) begin
                    bus.tx_wr <= 1'b1;
                    if (nib == 4'd8)
                        state <= WRITE;
                    else if (byte_q == 8'h47 && word_cnt != '0)
                        state <= RUN;
                    else begin
                        state <= IDLE;
                        if (byte_q == 8'h47)
                            err <= 1'b1;
                    end
                end
                WRITE: begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= word_cnt[ADDR_W-1:0];
                    bus.imem_wdata <= word;
                    word_cnt       <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
                    nib            <= '0;
`ifdef LOADER_AUTOSTART_EN
                    state          <= (word_cnt == {1'b0, {ADDR_W{1'b1}}}) ? RUN : IDLE;
`else
                    state          <= IDLE;
`endif
                end
                RUN: begin
                    bus.rx_clr <= fresh;
                    if (fresh && bus.rx_data == 8'h52) begin
                        cpu_start <= 1'b0;
                        word_cnt  <= '0;
                        nib       <= '0;
                        err       <= 1'b0;
                        state     <= IDLE;
                    end else if (cpu_halted) begin
                        cpu_start <= 1'b0;
                        state     <= HALT_TX;
                    end else
                        cpu_start <= 1'b1;
                end
                HALT_TX: if (!bus.tx_busy) begin
                    bus.tx_wr   <= 1'b1;
                    bus.tx_data <= 8'h48;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized directed bench for uart_prog_loader against a byte-level loader model
module tb_uart_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_halted;
    logic       cpu_start;
    logic       err;
    logic [4:0] word_cnt;

    uart_prog_loader_if #(.ADDR_W(4)) bus ();
    uart_prog_loader #(.ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cpu_halted(cpu_halted),
        .cpu_start(cpu_start), .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;
    logic [7:0]  tx_q[$];
    logic [35:0] wr_q[$];
    int clr_n = 0;
    logic [7:0]  exp_tx[$];
    logic [35:0] exp_wr[$];
    int exp_clr, tx_b, wr_b, clr_b;
    int m_cnt;
    bit m_err, m_run;
    int m_dig[$];

    // Record every transmit strobe, memory write and receive clear
    always @(negedge clk) begin
        if (bus.tx_wr) tx_q.push_back(bus.tx_data);
        if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (bus.rx_clr) clr_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        tx_b = tx_q.size();
        wr_b = wr_q.size();
        clr_b = clr_n;
        exp_tx.delete();
        exp_wr.delete();
        exp_clr = 0;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_err = 0;
        m_run = 0;
        m_dig.delete();
        flush();
    endtask

    task automatic model(input logic [7:0] b);
        logic [31:0] w;
        int v;
        exp_clr++;
        if (m_run) begin
            if (b == 8'h52) begin
                m_run = 0; m_cnt = 0; m_err = 0; m_dig.delete();
            end
        end else if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46)) begin
            if (m_cnt == 16) begin
                m_err = 1;
                exp_tx.push_back(8'h3F);
            end else begin
                exp_tx.push_back(b);
                v = (b <= 8'h39) ? int'(b) - 48 : int'(b) - 55;
                m_dig.push_back(v);
                if (m_dig.size() == 8) begin
                    w = 0;
                    for (int i = 0; i < 8; i++) w = w * 32'd16 + 32'(m_dig[i]);
                    exp_wr.push_back({m_cnt[3:0], w});
                    m_cnt++;
                    m_dig.delete();
                end
            end
        end else if (b == 8'h52) begin
            exp_tx.push_back(b);
            m_cnt = 0; m_err = 0; m_dig.delete();
        end else if (b == 8'h47) begin
            exp_tx.push_back(b);
            if (m_cnt == 0) m_err = 1;
            else m_run = 1;
        end else if (b == 8'h0D || b == 8'h0A) begin
            exp_tx.push_back(b);
        end else begin
            m_err = 1;
            m_dig.delete();
            exp_tx.push_back(8'h3F);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic present(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy = 1'b1;
    endtask

    // Receiver-side behaviour: rx_rdy drops on the clock edge that sees rx_clr
    task automatic await_cap();
        int k = 0;
        @(negedge clk);
        while (!bus.rx_clr && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("byte capture", bus.rx_clr, 1);
        @(posedge clk);
        #1 bus.rx_rdy = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        model(b);
        present(b);
        await_cap();
        settle(4);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        logic [3:0] d;
        for (int i = n - 1; i >= 0; i--) begin
            d = w[i*4 +: 4];
            send(d < 4'd10 ? 8'h30 + 8'(d) : 8'h37 + 8'(d));
            if ($urandom_range(0, 7) == 0) send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        end
    endtask

    task automatic run_g();
        int k = 0;
        model(8'h47);
        present(8'h47);
        await_cap();
        @(negedge clk);
        while (!bus.tx_wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("G echo strobe", bus.tx_wr, 1);
        chk("G echo byte", bus.tx_data, 8'h47);
        chk("cpu_start during G echo", cpu_start, 0);
        @(negedge clk);
        chk("cpu_start after G echo", cpu_start, 1);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, " tx count"}, tx_q.size() - tx_b, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && tx_b + i < tx_q.size(); i++)
            chk({tag, " tx byte"}, tx_q[tx_b + i], exp_tx[i]);
        chk({tag, " write count"}, wr_q.size() - wr_b, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr_b + i < wr_q.size(); i++)
            chk({tag, " write addr/data"}, wr_q[wr_b + i], exp_wr[i]);
        chk({tag, " rx_clr count"}, clr_n - clr_b, exp_clr);
        chk({tag, " word_cnt"}, word_cnt, m_cnt);
        chk({tag, " err"}, err, m_err);
        chk({tag, " cpu_start"}, cpu_start, m_run);
        flush();
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0] b;
        int n0, c0;
        rst_n = 1'b0;
        cpu_halted = 1'b0;
        bus.rx_data = '0;
        bus.rx_rdy = 1'b0;
        bus.tx_busy = 1'b0;
        model_reset();
        settle(3);
        chk("reset cpu_start", cpu_start, 0);
        chk("reset tx_wr", bus.tx_wr, 0);
        chk("reset rx_clr", bus.rx_clr, 0);
        chk("reset imem_we", bus.imem_we, 0);
        chk("reset err", err, 0);
        chk("reset tx_data", bus.tx_data, 0);
        chk("reset imem_addr", bus.imem_addr, 0);
        chk("reset imem_wdata", bus.imem_wdata, 0);
        chk("reset word_cnt", word_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(2);
        flush();

        send_str("00500093");
        cmp_q("single word");

        send_str("R0050x00A00113");
        cmp_q("bad char");

        send("R");
        for (int i = 0; i < 16; i++) send_word($urandom, 8);
        send("1");
        cmp_q("full memory");

        send("R");
        send_word($urandom, 8);
        send_word($urandom, 8);
        run_g();
        send("5");
        send(8'($urandom_range(48, 70)) == 8'h52 ? 8'h30 : 8'($urandom_range(48, 70)));
        chk("cpu_start while running", cpu_start, 1);
        @(negedge clk);
        cpu_halted = 1'b1;
        @(negedge clk);
        chk("cpu_start after halt", cpu_start, 0);
        m_run = 0;
        exp_tx.push_back(8'h48);
        settle(5);
        cpu_halted = 1'b0;
        cmp_q("run and halt");

        send("R");
        @(negedge clk);
        bus.tx_busy = 1'b1;
        model(8'h37);
        present(8'h37);
        await_cap();
        model(8'h33);
        present(8'h33);
        n0 = tx_q.size();
        c0 = clr_n;
        repeat (500) @(negedge clk);
        #1;
        chk("no tx_wr while busy", tx_q.size(), n0);
        chk("no capture while busy", clr_n, c0);
        @(negedge clk);
        bus.tx_busy = 1'b0;
        await_cap();
        settle(6);
        chk("pending byte captured once", clr_n, c0 + 1);
        cmp_q("tx stall");

        send("R");
        repeat (40) begin
            b = 8'($urandom_range(32, 126));
            send(b == 8'h47 ? 8'h0A : b);
        end
        settle(4);
        cmp_q("random bytes");

        send("R");
        send_word($urandom, 8);
        run_g();
        settle(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset cpu_start", cpu_start, 0);
        chk("async reset word_cnt", word_cnt, 0);
        chk("async reset tx_data", bus.tx_data, 0);
        chk("async reset imem_wdata", bus.imem_wdata, 0);
        chk("async reset err", err, 0);
        model_reset();
        w = $urandom & 32'h0FFF_FFFF;
        model(8'h30);
        present(8'h30);
        @(negedge clk);
        rst_n = 1'b1;
        await_cap();
        settle(4);
        send_word(w, 7);
        run_g();
        settle(4);
        model(8'h52);
        @(negedge clk);
        bus.rx_data = 8'h52;
        bus.rx_rdy = 1'b1;
        cpu_halted = 1'b1;
        await_cap();
        settle(6);
        cpu_halted = 1'b0;
        settle(2);
        cmp_q("reset and R wins");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Command sequencer between the UART byte interface and the CPU instruction memory. It parses ASCII hex from the UART receiver, packs eight nibbles MSB-first into 32-bit instruction words, and writes them to consecutive instruction-memory addresses. It echoes every received byte over the UART transmitter. It also starts the CPU and stops it, replacing ad-hoc loading logic with a single state machine.

## Interface
- `ADDR_W`, default 4: instruction-memory address width; depth is 2^ADDR_W words.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte from UART.
- `rx_rdy` in 1: received byte valid; level, held until cleared.
- `rx_clr` out 1: one-cycle pulse that clears `rx_rdy`.
- `tx_busy` in 1: transmitter busy.
- `tx_data` out 8: byte to transmit.
- `tx_wr` out 1: one-cycle transmit strobe.
- `imem_we` out 1: instruction-memory write strobe, one cycle.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 32: write data.
- `cpu_start` out 1: CPU run enable, level.
- `cpu_halted` in 1: CPU has executed ebreak.
- `word_cnt` out ADDR_W+1: number of words loaded, 0..2^ADDR_W.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, ECHO, WRITE, RUN, HALT_TX.
- **IDLE**, when `rx_rdy`=1:
  - Capture `rx_data`.
  - Pulse `rx_clr`.
  - Classify the byte, then go to ECHO.
- **Byte classes:**
  - Hex digit, '0'-'9' or 'A'-'F': shift the nibble into the word register at the LSB end; the nibble counter increments.
  - 'G' (0x47): run request.
  - 'R' (0x52): clear `word_cnt`, the nibble counter and `err`.
  - CR (0x0D) or LF (0x0A): ignored, but echoed.
  - Anything else: sets `err`, discards the partial word (nibble counter to 0), and the echo byte is '?' (0x3F).
  - Hex digit while `word_cnt` = 2^ADDR_W: sets `err`, the digit is discarded, and the echo byte is '?'.
- **ECHO:** wait while `tx_busy`=1, then pulse `tx_wr` with the echo byte. Next state:
  - WRITE, if this byte completed 8 nibbles.
  - RUN, if the byte was 'G' and `word_cnt`>0.
  - IDLE otherwise. 'G' with `word_cnt`=0 sets `err`.
- **WRITE:**
  - Pulse `imem_we` with `imem_addr`=`word_cnt`[ADDR_W-1:0] and `imem_wdata` = assembled word.
  - `word_cnt`+1, nibble counter to 0, then IDLE.
- **RUN:**
  - `cpu_start`=1.
  - Incoming bytes are cleared with `rx_clr` and not echoed, except 'R', which drops `cpu_start`, performs the 'R' clears and returns to IDLE.
  - `cpu_halted`=1 leads to HALT_TX.
- **HALT_TX:** `cpu_start` drops. Wait for `!tx_busy`, send 'H' (0x48), then IDLE.
- The word register and nibble counter are unchanged by 'G', CR and LF.

## Timing
- Reset values:
  - `cpu_start`, `tx_wr`, `rx_clr`, `imem_we`, `err` = 0.
  - `tx_data`, `imem_wdata`, `imem_addr`, `word_cnt` = 0.
  - State = IDLE.
- Reset asserted mid-operation aborts immediately.
  - Outputs return to reset values asynchronously.
  - A pending `rx_rdy` is handled normally after release.
- All outputs are registered.
- Byte capture, echo latency and pipeline interlocks:
  - `rx_clr` is high in cycle N+1 after capture edge N.
  - The earliest `tx_wr` is in cycle N+2.
  - The FSM does not re-sample `rx_rdy` before N+3, so a stale `rx_rdy` is never captured twice.
- `imem_we` follows in the cycle after the `tx_wr` of the eighth nibble.
- Throughput: one byte per UART frame. Bytes are never lost while `tx_busy` stalls echo, provided the transmitter frame time is no longer than the receiver frame time.
- `cpu_start` rises in the cycle after the 'G' echo strobe.
- `cpu_start` falls in the cycle after `cpu_halted` is sampled high.
- `cpu_halted` and 'R' arriving on the same edge: 'R' wins. The FSM goes to IDLE and no 'H' is sent.

## Configuration
- `LOADER_AUTOSTART_EN`:
  - Defined: after the WRITE that makes `word_cnt` = 2^ADDR_W, go directly to RUN without needing 'G'.
  - Undefined: a full memory stays in IDLE until 'G'.

## Test plan
- Send "00500093" → one `imem_we`, addr 0, data 0x00500093. `word_cnt`=1, 8 echoes identical to the input.
- Send "0050", 'x', "00A00113" → `err`=1, echoes "0050?00A00113". One write: addr 0, data 0x00A00113.
- Load 16 words, then one more digit '1' → 16 writes at addr 0..15, echo '?', `err`=1, `word_cnt`=16.
- Load 2 words, send 'G', later drive `cpu_halted`=1 → `cpu_start` high until halt, then 'H' (0x48) transmitted.
- Hold `tx_busy`=1 for 500 cycles across a received byte → `tx_wr` is issued only after `tx_busy` falls. The next byte is captured exactly once.
- Assert `rst_n`=0 during RUN, then send 'R' while running after re-start → outputs are zero at once; `cpu_start` drops, `word_cnt`=0.
